// File: rtl/sr_ff_if.sv
// sr_ff_if: set/reset request bus and registered state for a WIDTH-bit sr_ff.
// With SR_FF_CONFLICT_HOLD_EN defined, the bus also carries the per-bit sr_conflict flag.
interface sr_ff_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
`ifdef SR_FF_CONFLICT_HOLD_EN
    logic [WIDTH-1:0] sr_conflict;

    modport master (output s, output r, input q, input qn, input sr_conflict);
    modport slave  (input s, input r, output q, output qn, output sr_conflict);
`else
    modport master (output s, output r, input q, input qn);
    modport slave  (input s, input r, output q, output qn);
`endif
endinterface

// File: rtl/sr_ff.sv
// sr_ff: WIDTH independent synchronous SR cells, each built as a JK core
// with J=s and K=r. With the default build, s=r=1 toggles the bit.
// Optional macro SR_FF_CONFLICT_HOLD_EN: s=r=1 holds the bit instead and
// raises the matching sr_conflict bit for the following cycle.

module sr_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
`ifdef SR_FF_CONFLICT_HOLD_EN
    output logic conflict,
`endif
    output logic q
);
    logic jk_next;
    logic d;

    // JK next state: J sets, K clears, both toggle
    always_comb begin
        jk_next = (s & ~q) | (~r & q);
`ifdef SR_FF_CONFLICT_HOLD_EN
        d = (s & r) ? q : jk_next;
`else
        d = jk_next;
`endif
    end

    // State register; reset has priority over s and r
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

`ifdef SR_FF_CONFLICT_HOLD_EN
    // Conflict flag lives for exactly the cycle after an s=r=1 edge
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict <= 1'b0;
        end else begin
            conflict <= s & r;
        end
    end
`endif
endmodule

module sr_ff #(
    parameter int WIDTH = 1
) (
    input logic   clk,
    input logic   rst,
    sr_ff_if.slave bus
);
    logic [WIDTH-1:0] q_w;
`ifdef SR_FF_CONFLICT_HOLD_EN
    logic [WIDTH-1:0] conflict_w;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_ff_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .s        (bus.s[i]),
            .r        (bus.r[i]),
`ifdef SR_FF_CONFLICT_HOLD_EN
            .conflict (conflict_w[i]),
`endif
            .q        (q_w[i])
        );
    end

    // qn is a pure inversion of the stored bit, not a second register
    assign bus.q  = q_w;
    assign bus.qn = ~q_w;
`ifdef SR_FF_CONFLICT_HOLD_EN
    assign bus.sr_conflict = conflict_w;
`endif
endmodule

// File: tb/tb_sr_ff.sv
// tb_sr_ff: directed self-checking bench for sr_ff at WIDTH=4.
// Expectations follow SR_FF_CONFLICT_HOLD_EN when it is defined.
module tb_sr_ff;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    sr_ff_if #(.WIDTH(W)) bus ();

    sr_ff #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns period, first rising edge at 5 ns
    always #5 clk = ~clk;

    // Apply inputs, take one edge, settle 1 ns past it
    task automatic tick(input logic rv, input logic [W-1:0] sv, input logic [W-1:0] rr);
        rst   = rv;
        bus.s = sv;
        bus.r = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 4'h0, 4'h0);
        n_chk++;
        if (bus.q !== 4'h0) begin n_fail++; $display("FAIL reset_q got %b want 0000", bus.q); end
        n_chk++;
        if (bus.qn !== 4'hF) begin n_fail++; $display("FAIL reset_qn got %b want 1111", bus.qn); end
`ifdef SR_FF_CONFLICT_HOLD_EN
        n_chk++;
        if (bus.sr_conflict !== 4'h0) begin n_fail++; $display("FAIL reset_conf got %b want 0000", bus.sr_conflict); end
`endif
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 4'h0, 4'h0);
            n_chk++;
            if (bus.q !== 4'h0 || bus.qn !== 4'hF) begin
                n_fail++; $display("FAIL hold_%0d got q=%b qn=%b want 0000/1111", k, bus.q, bus.qn);
            end
        end
    endtask

    task automatic test_set_clear();
        tick(1'b0, 4'h0, 4'hF);
        n_chk++;
        if (bus.q !== 4'h0) begin n_fail++; $display("FAIL clear_q got %b want 0000", bus.q); end
        tick(1'b0, 4'hF, 4'h0);
        n_chk++;
        if (bus.q !== 4'hF) begin n_fail++; $display("FAIL set_q got %b want 1111", bus.q); end
        n_chk++;
        if (bus.qn !== 4'h0) begin n_fail++; $display("FAIL set_qn got %b want 0000", bus.qn); end
        tick(1'b0, 4'h0, 4'h0);
        n_chk++;
        if (bus.q !== 4'hF) begin n_fail++; $display("FAIL set_hold got %b want 1111", bus.q); end
        tick(1'b0, 4'h0, 4'h5);
        n_chk++;
        if (bus.q !== 4'hA) begin n_fail++; $display("FAIL partial_clear got %b want 1010", bus.q); end
    endtask

    task automatic test_conflict();
        tick(1'b0, 4'hF, 4'h0);
        tick(1'b0, 4'hF, 4'hF);
`ifdef SR_FF_CONFLICT_HOLD_EN
        n_chk++;
        if (bus.q !== 4'hF) begin n_fail++; $display("FAIL conf_hold got %b want 1111", bus.q); end
        n_chk++;
        if (bus.sr_conflict !== 4'hF) begin n_fail++; $display("FAIL conf_flag got %b want 1111", bus.sr_conflict); end
        tick(1'b0, 4'h0, 4'h0);
        n_chk++;
        if (bus.q !== 4'hF) begin n_fail++; $display("FAIL conf_after got %b want 1111", bus.q); end
        n_chk++;
        if (bus.sr_conflict !== 4'h0) begin n_fail++; $display("FAIL conf_clear got %b want 0000", bus.sr_conflict); end
`else
        n_chk++;
        if (bus.q !== 4'h0) begin n_fail++; $display("FAIL toggle_1 got %b want 0000", bus.q); end
        tick(1'b0, 4'hF, 4'hF);
        n_chk++;
        if (bus.q !== 4'hF) begin n_fail++; $display("FAIL toggle_2 got %b want 1111", bus.q); end
`endif
    endtask

    task automatic test_back_to_back();
        // s=r=1 for 3 edges starting from 0011
        tick(1'b1, 4'h0, 4'h0);
        tick(1'b0, 4'h3, 4'h0);
        for (int k = 0; k < 3; k++) tick(1'b0, 4'hF, 4'hF);
        n_chk++;
`ifdef SR_FF_CONFLICT_HOLD_EN
        if (bus.q !== 4'h3) begin n_fail++; $display("FAIL b2b got %b want 0011", bus.q); end
`else
        if (bus.q !== 4'hC) begin n_fail++; $display("FAIL b2b got %b want 1100", bus.q); end
`endif
    endtask

    task automatic test_reset_priority();
        tick(1'b1, 4'h0, 4'h0);
        tick(1'b1, 4'hF, 4'h0);
        n_chk++;
        if (bus.q !== 4'h0) begin n_fail++; $display("FAIL rst_prio got %b want 0000", bus.q); end
        tick(1'b0, 4'hF, 4'h0);
        n_chk++;
        if (bus.q !== 4'hF) begin n_fail++; $display("FAIL rst_release got %b want 1111", bus.q); end
        // reset mid-operation, then SR rules from q=0
        tick(1'b1, 4'h0, 4'h0);
        tick(1'b0, 4'hF, 4'hF);
        n_chk++;
`ifdef SR_FF_CONFLICT_HOLD_EN
        if (bus.q !== 4'h0) begin n_fail++; $display("FAIL rst_then_conf got %b want 0000", bus.q); end
`else
        if (bus.q !== 4'hF) begin n_fail++; $display("FAIL rst_then_conf got %b want 1111", bus.q); end
`endif
    endtask

    task automatic test_independence();
        tick(1'b1, 4'h0, 4'h0);
        tick(1'b0, 4'h5, 4'hA);
        n_chk++;
        if (bus.q !== 4'b0101) begin n_fail++; $display("FAIL indep_pre got %b want 0101", bus.q); end
        // bit0 conflict, bit1 set, bit2 hold, bit3 clear
        tick(1'b0, 4'b0011, 4'b1001);
        n_chk++;
`ifdef SR_FF_CONFLICT_HOLD_EN
        if (bus.q !== 4'b0111) begin n_fail++; $display("FAIL indep got %b want 0111", bus.q); end
        n_chk++;
        if (bus.sr_conflict !== 4'b0001) begin n_fail++; $display("FAIL indep_conf got %b want 0001", bus.sr_conflict); end
`else
        if (bus.q !== 4'b0110) begin n_fail++; $display("FAIL indep got %b want 0110", bus.q); end
`endif
        n_chk++;
        if (bus.qn !== ~bus.q) begin n_fail++; $display("FAIL indep_qn got %b q=%b", bus.qn, bus.q); end
    endtask

    initial begin
        bus.s = '0;
        bus.r = '0;
        test_reset();
        test_set_clear();
        test_conflict();
        test_back_to_back();
        test_reset_priority();
        test_independence();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
